pe_mac_acc: RTL and testbench

- Next-generation systolic-array processing element for the matrix-multiply fabric.
- Operands flow west→east and north→south with a 1-cycle register per hop; each PE multiply-accumulates one output element.
- Adds signed/unsigned mode, a widened accumulator, fixed-point rounding with saturation, and a back-pressured result drain chain (valid/ready) with a 2-entry skid buffer.
- The drain chain replaces the free-running result shift.

---
 rtl/pe_pkg.sv | 53 +++++
 rtl/pe_drain_fifo.sv | 65 ++++++
 rtl/pe_mac_acc.sv | 152 +++++++++++++++
 tb/tb_pe_mac_acc.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/pe_pkg.sv
// Shared helpers for the MAC processing element: operand-mode encoding and
// the fixed-point round/saturate functions used when a result is formed.
package pe_pkg;

  localparam bit MODE_UNSIGNED = 1'b0;
  localparam bit MODE_SIGNED   = 1'b1;

  // Result formation runs at a fixed 64-bit width so any ACC_LEN up to 62 fits.
  localparam int WIDE = 64;
  typedef logic [WIDE-1:0] wide_t;

  typedef struct packed {
    logic  sat;
    wide_t val;
  } clamp_t;

  function automatic wide_t round_shift(input wide_t val, input int unsigned shift,
                                        input bit mode);
    wide_t biased;
    biased = val;
    if (shift != 0) biased = val + (wide_t'(1) << (shift - 1));
    if (mode == MODE_SIGNED) return wide_t'($signed(biased) >>> shift);
    return biased >> shift;
  endfunction

  function automatic clamp_t sat_clamp(input wide_t val, input int unsigned out_len,
                                       input bit mode);
    wide_t  hi;
    wide_t  lo;
    clamp_t r;
    r.sat = 1'b0;
    r.val = val;
    if (mode == MODE_SIGNED) begin
      hi = (wide_t'(1) << (out_len - 1)) - wide_t'(1);
      lo = ~hi;
      if ($signed(val) > $signed(hi)) begin
        r.sat = 1'b1;
        r.val = hi;
      end else if ($signed(val) < $signed(lo)) begin
        r.sat = 1'b1;
        r.val = lo;
      end
    end else begin
      hi = (wide_t'(1) << out_len) - wide_t'(1);
      if (val > hi) begin
        r.sat = 1'b1;
        r.val = hi;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/pe_drain_fifo.sv
// Two-entry valid/ready FIFO for the result drain chain; accepts a push in the
// same cycle as a pop even when full. The head reads 0 whenever it is empty.
module pe_drain_fifo #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         sys_rst_n,
  input  logic         push_val,
  input  logic [W-1:0] push_data,
  output logic         push_rdy,
  input  logic         pop_rdy,
  output logic         head_val,
  output logic [W-1:0] head_data
);

  localparam int DEPTH = 2;

  logic [W-1:0] mem_q [DEPTH];
  logic         rd_ptr_q;
  logic         wr_ptr_q;
  logic [1:0]   count_q;
  logic [1:0]   count_d;
  logic         push;
  logic         pop;
  logic [DEPTH-1:0] wr_en;

  assign head_val  = (count_q != 2'd0);
  assign head_data = head_val ? mem_q[rd_ptr_q] : '0;
  assign pop       = head_val && pop_rdy;
  assign push_rdy  = (count_q < 2'd2) || pop;
  assign push      = push_val && push_rdy;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_wr_en
      assign wr_en[gi] = push && (wr_ptr_q == 1'(gi));
    end
  endgenerate

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (wr_en[i]) mem_q[i] <= push_data;
      end
      if (push) wr_ptr_q <= ~wr_ptr_q;
      if (pop)  rd_ptr_q <= ~rd_ptr_q;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/pe_mac_acc.sv
// Systolic-array MAC element: forwards operands east/south, accumulates one
// output element, rounds/saturates it and merges it into the drain chain.
module pe_mac_acc
  import pe_pkg::*;
#(
  parameter int IN_LEN      = 8,
  parameter int ACC_LEN     = 24,
  parameter int OUT_LEN     = 16,
  parameter int FRAC_SHIFT  = 0,
  parameter int SIGNED_MODE = 1
) (
  input  logic               clk,
  input  logic               sys_rst_n,
  input  logic               cal_en,
  input  logic               cal_done,
  input  logic [IN_LEN-1:0]  westin,
  input  logic [IN_LEN-1:0]  northin,
  output logic               n_cal_en,
  output logic               n_cal_done,
  output logic [IN_LEN-1:0]  eastout,
  output logic [IN_LEN-1:0]  southout,
  input  logic               din_val,
  input  logic [OUT_LEN-1:0] din,
  output logic               din_rdy,
  output logic               dout_val,
  output logic [OUT_LEN-1:0] dout,
  input  logic               dout_rdy,
  output logic               ovf_err,
  output logic               sat_flag
);

  localparam int PW   = 2 * IN_LEN;
  localparam bit MODE = (SIGNED_MODE != 0) ? MODE_SIGNED : MODE_UNSIGNED;

  logic                     en_q, done_q;
  logic [ACC_LEN-1:0]       product_q, product_d;
  logic [ACC_LEN-1:0]       acc_q, acc_d, final_sum;
  logic signed [PW-1:0]     w_ext, n_ext, prod_raw;
  logic                     n_cal_en_q, n_cal_done_q;
  logic [IN_LEN-1:0]        eastout_q, southout_q;
  wide_t                    fin_wide, rounded;
  clamp_t                   clamp;
  logic                     res_valid;
  logic [OUT_LEN-1:0]       res_data;
  logic                     unused_clamp_hi;
  logic                     pend_valid_q, pend_valid_d;
  logic [OUT_LEN-1:0]       pend_q, pend_d;
  logic                     ovf_q, ovf_d, sat_q, sat_d;
  logic                     fifo_rdy, push_val;
  logic [OUT_LEN-1:0]       push_data;

  assign n_cal_en   = n_cal_en_q;
  assign n_cal_done = n_cal_done_q;
  assign eastout    = eastout_q;
  assign southout   = southout_q;
  assign ovf_err    = ovf_q;
  assign sat_flag   = sat_q;

  always_comb begin
    if (MODE == MODE_SIGNED) begin
      w_ext = PW'($signed(westin));
      n_ext = PW'($signed(northin));
    end else begin
      w_ext = PW'(westin);
      n_ext = PW'(northin);
    end
    prod_raw  = w_ext * n_ext;
    product_d = '0;
    if (cal_en) begin
      if (MODE == MODE_SIGNED) product_d = ACC_LEN'(prod_raw);
      else                     product_d = ACC_LEN'($unsigned(prod_raw));
    end
  end

  // Completing sum bypasses acc so the next accumulation starts from 0 without a bubble.
  always_comb begin
    final_sum = acc_q + product_q;
    res_valid = en_q && done_q;
    acc_d     = acc_q;
    if (en_q) acc_d = done_q ? '0 : final_sum;
    if (MODE == MODE_SIGNED) fin_wide = WIDE'($signed(final_sum));
    else                     fin_wide = WIDE'(final_sum);
    rounded  = round_shift(fin_wide, FRAC_SHIFT, MODE);
    clamp    = sat_clamp(rounded, OUT_LEN, MODE);
    res_data = clamp.val[OUT_LEN-1:0];
  end

  assign unused_clamp_hi = ^clamp.val[WIDE-1:OUT_LEN];

  // The pending local result always wins the FIFO write port over upstream words.
  assign din_rdy   = !pend_valid_q && fifo_rdy;
  assign push_val  = pend_valid_q || (din_val && din_rdy);
  assign push_data = pend_valid_q ? pend_q : din;

  always_comb begin
    pend_valid_d = pend_valid_q && !fifo_rdy;
    pend_d       = pend_q;
    ovf_d        = ovf_q;
    sat_d        = 1'b0;
    if (res_valid) begin
      if (pend_valid_q && !fifo_rdy) begin
        ovf_d = 1'b1;
      end else begin
        pend_valid_d = 1'b1;
        pend_d       = res_data;
        sat_d        = clamp.sat;
      end
    end
  end

  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      en_q         <= 1'b0;
      done_q       <= 1'b0;
      product_q    <= '0;
      acc_q        <= '0;
      n_cal_en_q   <= 1'b0;
      n_cal_done_q <= 1'b0;
      eastout_q    <= '0;
      southout_q   <= '0;
      pend_valid_q <= 1'b0;
      pend_q       <= '0;
      ovf_q        <= 1'b0;
      sat_q        <= 1'b0;
    end else begin
      en_q         <= cal_en;
      done_q       <= cal_en && cal_done;
      product_q    <= product_d;
      acc_q        <= acc_d;
      n_cal_en_q   <= cal_en;
      n_cal_done_q <= cal_done;
      eastout_q    <= cal_en ? westin : '0;
      southout_q   <= cal_en ? northin : '0;
      pend_valid_q <= pend_valid_d;
      pend_q       <= pend_d;
      ovf_q        <= ovf_d;
      sat_q        <= sat_d;
    end
  end

  pe_drain_fifo #(.W(OUT_LEN)) u_fifo (
    .clk       (clk),
    .sys_rst_n (sys_rst_n),
    .push_val  (push_val),
    .push_data (push_data),
    .push_rdy  (fifo_rdy),
    .pop_rdy   (dout_rdy),
    .head_val  (dout_val),
    .head_data (dout)
  );

endmodule

// File: tb/tb_pe_mac_acc.sv
// Directed bench for pe_mac_acc: three instances (signed, unsigned, FRAC_SHIFT=4)
// share stimulus; each vector is checked on the instance it targets.
module tb_pe_mac_acc;

  logic        clk = 1'b0;
  logic        sys_rst_n;
  logic        cal_en, cal_done, din_val, dout_rdy;
  logic [7:0]  westin, northin;
  logic [15:0] din;

  logic        n_cal_en_w [3];
  logic        n_cal_done_w [3];
  logic [7:0]  eastout_w [3];
  logic [7:0]  southout_w [3];
  logic        din_rdy_w [3];
  logic        dout_val_w [3];
  logic [15:0] dout_w [3];
  logic        ovf_err_w [3];
  logic        sat_flag_w [3];

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_dut
      pe_mac_acc #(
        .IN_LEN(8), .ACC_LEN(24), .OUT_LEN(16),
        .FRAC_SHIFT((gi == 2) ? 4 : 0),
        .SIGNED_MODE((gi == 1) ? 0 : 1)
      ) u_dut (
        .clk(clk), .sys_rst_n(sys_rst_n),
        .cal_en(cal_en), .cal_done(cal_done),
        .westin(westin), .northin(northin),
        .n_cal_en(n_cal_en_w[gi]), .n_cal_done(n_cal_done_w[gi]),
        .eastout(eastout_w[gi]), .southout(southout_w[gi]),
        .din_val(din_val), .din(din), .din_rdy(din_rdy_w[gi]),
        .dout_val(dout_val_w[gi]), .dout(dout_w[gi]), .dout_rdy(dout_rdy),
        .ovf_err(ovf_err_w[gi]), .sat_flag(sat_flag_w[gi])
      );
    end
  endgenerate

  typedef struct {
    int          sel;
    int          np;
    int          rep;
    logic [31:0] wpk;
    logic [31:0] npk;
    logic [15:0] exp_dout;
    logic        exp_sat;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset(input string tag);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("%s n_cal_en[%0d]", tag, i),   32'(n_cal_en_w[i]),   32'd0);
      chk($sformatf("%s n_cal_done[%0d]", tag, i), 32'(n_cal_done_w[i]), 32'd0);
      chk($sformatf("%s eastout[%0d]", tag, i),    32'(eastout_w[i]),    32'd0);
      chk($sformatf("%s southout[%0d]", tag, i),   32'(southout_w[i]),   32'd0);
      chk($sformatf("%s dout[%0d]", tag, i),       32'(dout_w[i]),       32'd0);
      chk($sformatf("%s dout_val[%0d]", tag, i),   32'(dout_val_w[i]),   32'd0);
      chk($sformatf("%s ovf_err[%0d]", tag, i),    32'(ovf_err_w[i]),    32'd0);
      chk($sformatf("%s sat_flag[%0d]", tag, i),   32'(sat_flag_w[i]),   32'd0);
      chk($sformatf("%s din_rdy[%0d]", tag, i),    32'(din_rdy_w[i]),    32'd1);
    end
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    logic [7:0] wl, nl;
    int         s;
    s  = v.sel;
    wl = v.wpk[31-8*(v.np-1) -: 8];
    nl = v.npk[31-8*(v.np-1) -: 8];
    for (int r = 0; r < v.rep; r++) begin
      for (int p = 0; p < v.np; p++) begin
        step();
        cal_en   = 1'b1;
        westin   = v.wpk[31-8*p -: 8];
        northin  = v.npk[31-8*p -: 8];
        cal_done = (r == v.rep - 1) && (p == v.np - 1);
      end
    end
    step();
    cal_en = 1'b0; cal_done = 1'b0; westin = '0; northin = '0;
    chk($sformatf("v%0d eastout", idx),    32'(eastout_w[s]),    32'(wl));
    chk($sformatf("v%0d southout", idx),   32'(southout_w[s]),   32'(nl));
    chk($sformatf("v%0d n_cal_done", idx), 32'(n_cal_done_w[s]), 32'd1);
    step();
    chk($sformatf("v%0d sat_flag", idx),   32'(sat_flag_w[s]),   32'(v.exp_sat));
    chk($sformatf("v%0d early_val", idx),  32'(dout_val_w[s]),   32'd0);
    chk($sformatf("v%0d eastout_idle", idx), 32'(eastout_w[s]),  32'd0);
    step();
    chk($sformatf("v%0d dout_val", idx),   32'(dout_val_w[s]),   32'd1);
    chk($sformatf("v%0d dout", idx),       32'(dout_w[s]),       32'(v.exp_dout));
    $display("vec %0d dut %0d dout=%h sat=%0b", idx, s, dout_w[s], sat_flag_w[s]);
    step();
    chk($sformatf("v%0d drained", idx),    32'(dout_val_w[s]),   32'd0);
    chk($sformatf("v%0d dout_zero", idx),  32'(dout_w[s]),       32'd0);
    chk($sformatf("v%0d sat_pulse", idx),  32'(sat_flag_w[s]),   32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, n_bad=%0d", n_bad);
    $fatal(1);
  end

  initial begin
    vec_t rv;
    vecs[0] = '{0, 4, 1, 32'h0305FF02, 32'hFE04F902, 16'h0019, 1'b0};
    vecs[1] = '{0, 1, 8, 32'h7F000000, 32'h7F000000, 16'h7FFF, 1'b1};
    vecs[2] = '{1, 1, 8, 32'hFF000000, 32'hFF000000, 16'hFFFF, 1'b1};
    vecs[3] = '{2, 1, 1, 32'h07000000, 32'h05000000, 16'h0002, 1'b0};
    vecs[4] = '{2, 1, 1, 32'hF7000000, 32'h02000000, 16'hFFFF, 1'b0};
    vecs[5] = '{0, 1, 4, 32'h80000000, 32'h7F000000, 16'h8000, 1'b1};
    vecs[6] = '{1, 1, 1, 32'h0A000000, 32'h14000000, 16'h00C8, 1'b0};
    vecs[7] = '{2, 1, 1, 32'h08000000, 32'h01000000, 16'h0001, 1'b0};
    vecs[8] = '{2, 1, 1, 32'hF8000000, 32'h01000000, 16'h0000, 1'b0};
    vecs[9] = '{0, 1, 1, 32'hFF000000, 32'h01000000, 16'hFFFF, 1'b0};

    sys_rst_n = 1'b0; cal_en = 1'b0; cal_done = 1'b0; westin = '0; northin = '0;
    din_val = 1'b0; din = '0; dout_rdy = 1'b1;
    #3;
    chk_reset("reset");
    step();
    sys_rst_n = 1'b1;

    for (int i = 0; i < 10; i++) run_vec(i, vecs[i]);

    // Backpressure: two upstream words fill the FIFO, then drain in order.
    step();
    dout_rdy = 1'b0; din_val = 1'b1; din = 16'h0011;
    #2 chk("bp rdy_empty", 32'(din_rdy_w[0]), 32'd1);
    step();
    din = 16'h0022;
    #2 chk("bp rdy_one", 32'(din_rdy_w[0]), 32'd1);
    chk("bp head_one", 32'(dout_w[0]), 32'h0011);
    step();
    din_val = 1'b0; din = '0;
    #2 chk("bp rdy_full", 32'(din_rdy_w[0]), 32'd0);
    chk("bp head_full", 32'(dout_w[0]), 32'h0011);
    dout_rdy = 1'b1;
    #2 chk("bp rdy_popping", 32'(din_rdy_w[0]), 32'd1);
    step();
    #2 chk("bp second", 32'(dout_w[0]), 32'h0022);
    step();
    #2 chk("bp empty_val", 32'(dout_val_w[0]), 32'd0);
    chk("bp empty_rdy", 32'(din_rdy_w[0]), 32'd1);
    $display("backpressure sequence done");

    // Collision: full FIFO, two back-to-back local results, second one lost.
    chk("col ovf_before", 32'(ovf_err_w[0]), 32'd0);
    step();
    dout_rdy = 1'b0; din_val = 1'b1; din = 16'h00A1;
    step();
    din = 16'h00A2;
    step();
    din_val = 1'b0; din = '0;
    cal_en = 1'b1; cal_done = 1'b1; westin = 8'd2; northin = 8'd3;
    step();
    westin = 8'd4; northin = 8'd5;
    step();
    cal_en = 1'b0; cal_done = 1'b0; westin = '0; northin = '0;
    step();
    #2 chk("col ovf_set", 32'(ovf_err_w[0]), 32'd1);
    chk("col din_blocked", 32'(din_rdy_w[0]), 32'd0);
    chk("col head", 32'(dout_w[0]), 32'h00A1);
    dout_rdy = 1'b1;
    step();
    #2 chk("col word2", 32'(dout_w[0]), 32'h00A2);
    step();
    #2 chk("col local", 32'(dout_w[0]), 32'h0006);
    chk("col local_val", 32'(dout_val_w[0]), 32'd1);
    step();
    #2 chk("col empty", 32'(dout_val_w[0]), 32'd0);
    chk("col ovf_sticky", 32'(ovf_err_w[0]), 32'd1);
    $display("collision sequence done");

    // Reset mid-accumulation, then a fresh single-pair run.
    step();
    cal_en = 1'b1; westin = 8'd3; northin = 8'd3;
    step();
    step();
    sys_rst_n = 1'b0; cal_done = 1'b1; westin = 8'd9;
    #2 chk_reset("midrst");
    step();
    chk_reset("midrst_held");
    step();
    sys_rst_n = 1'b1; cal_en = 1'b0; cal_done = 1'b0; westin = '0; northin = '0;
    rv = '{0, 1, 1, 32'h06000000, 32'h07000000, 16'h002A, 1'b0};
    run_vec(10, rv);
    chk("rst ovf_clear", 32'(ovf_err_w[0]), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
